uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; sits directly downstream of baud_rate_gen and consumes its rxclk_en (16x-oversample tick) on the clk_50m domain.
- Deserialises 8N1 frames from the asynchronous rx pin, LSB first, and presents each good byte with a sticky ready flag for the host logic.
- Flags framing errors and overruns.

Parameters:
- DATA_BITS, 8, payload bits per frame.
- OVERSAMPLE, 16, rxclk_en ticks per bit period; must be even and at least 4.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- rxclk_en  in  1  one-cycle oversample tick from baud_rate_gen.
- rx  in  1  asynchronous serial input; idle high.
- rdy_clr  in  1  one-cycle pulse; consumer acknowledges data.
- data  out  DATA_BITS  last good received byte.
- rdy  out  1  sticky; a new byte is valid.
- frame_err  out  1  sticky; last frame had stop bit = 0.
- overrun  out  1  sticky; a byte completed while rdy was still 1.

Behaviour:
- Interface: one clock, clk_50m. Reset rst is synchronous and active-high.
- Reset values:
  - data = 0, rdy = 0, frame_err = 0, overrun = 0.
  - FSM = IDLE, tick counter = 0, bit counter = 0.
  - Synchroniser flops = 1, previous-rx register = 1.
- Synchronisation:
  - rx passes through a 2-flop synchroniser, giving rx_s.
  - rx_s lags the pin by 2 clk_50m cycles.
  - All decisions use rx_s.
- State advance: all FSM and counter updates occur only on cycles with rxclk_en = 1. Only the sticky-flag clear via rdy_clr acts on any cycle.
- IDLE:
  - On a tick where rx_s = 0 and the previous sampled rx_s = 1, go to START with tick count = 0.
  - Edge detection stops a held-low line (break) from retriggering.
- START:
  - Count ticks. At tick index OVERSAMPLE/2-1 (index 7), check rx_s.
  - rx_s = 0: go to DATA, tick count = 0, bit count = 0.
  - rx_s = 1: glitch; go to IDLE with no flag change.
- DATA:
  - At tick index OVERSAMPLE-1, i.e. 16 ticks after the previous sample (mid-bit), shift rx_s into the shift register MSB; net effect is LSB first.
  - Then reset the tick count and increment the bit count.
  - After DATA_BITS samples, go to STOP.
- STOP: at tick index OVERSAMPLE-1, sample rx_s.
  - rx_s = 1: data <= shift register; frame_err <= 0. If rdy is already 1, overrun <= 1. Then rdy <= 1.
  - rx_s = 0: frame_err <= 1; data and rdy unchanged.
  - Either case: go to IDLE.
- Latency: data, rdy and frame_err update on the clk_50m edge after the rxclk_en cycle on which the stop bit is sampled.
- rdy_clr:
  - Clears rdy and overrun on the next edge. frame_err is not cleared by rdy_clr.
  - If rdy_clr and a good stop coincide, the set wins: rdy = 1 and data is the new byte. overrun is not set in this case, because the old byte was consumed.
- rst mid-frame: the FSM returns to IDLE within one cycle, the partial byte is discarded, and all outputs return to reset values.
- rxclk_en held low: the FSM freezes, with no timeout.
- Counter widths:
  - Tick counter: $clog2(OVERSAMPLE) bits; wraps only through explicit reset.
  - Bit counter: $clog2(DATA_BITS+1) bits.

Decomposition:
- Package uart_pkg:
  - rx FSM state enum {IDLE, START, DATA, STOP}, 2 bits.
  - Constants UART_OVERSAMPLE = 16 and UART_DATA_BITS = 8, shared with baud_rate_gen and the future uart_tx.
- Sub-module uart_sync2: generic 2-flop synchroniser, reset value 1, reusable for other async inputs.

Test Plan:
- Good byte: rxclk_en every 4 cycles (bit = 64 cycles); send 0xA5 as 8N1 -> data = 0xA5, rdy = 1, frame_err = 0, overrun = 0; rdy_clr pulse -> rdy = 0.
- Back-to-back: send 0x00 then 0xFF, rdy_clr pulsed between them -> data sequence 0x00 then 0xFF, each with rdy rising once, no overrun.
- Framing error: send 0x3C with stop bit driven 0 -> frame_err = 1, rdy stays 0, data keeps its prior value. A following good 0x55 -> frame_err = 0, data = 0x55.
- Glitch and break:
  - Pulse rx low for 16 clk_50m cycles (4 ticks) -> FSM returns to IDLE, no rdy.
  - Hold rx low for 20 bit times -> exactly one frame_err event, with no repeated frames until rx returns high.
- Overrun and coincidence:
  - Send 0x11 then 0x22 without rdy_clr -> data = 0x22, overrun = 1.
  - Repeat with rdy_clr on the exact stop-update cycle -> rdy = 1, overrun = 0.
- Reset mid-frame: assert rst for 1 cycle during bit 3 of 0x81 -> all outputs 0; the next full 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and constants (rx FSM states, frame geometry)
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// uart_sync2 : two-flop synchroniser for one asynchronous input, preset on rst
// Revision   : 1.0
// ============================================================================
`default_nettype none

module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 receiver on 16x oversample ticks, sticky rdy/frame_err/overrun
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] C_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            r_state, w_state_next;
  logic [TW-1:0]        r_tick_cnt, w_tick_next;
  logic [BW-1:0]        r_bit_cnt, w_bit_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_prev;
  logic                 w_rx_s;
  logic                 w_shift_en, w_stop_good, w_stop_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_50m),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_next;
      r_bit_cnt  <= w_bit_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_en   = 1'b0;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    if (rxclk_en) begin
      w_tick_next = r_tick_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          // Falling edge only, so a line held low cannot restart a frame.
          w_tick_next = '0;
          if (!w_rx_s && r_rx_prev) w_state_next = START;
        end
        START: begin
          if (r_tick_cnt == C_TICK_MID) begin
            w_tick_next  = '0;
            w_bit_next   = '0;
            w_state_next = w_rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (r_tick_cnt == C_TICK_LAST) begin
            w_tick_next = '0;
            w_bit_next  = r_bit_cnt + 1'b1;
            w_shift_en  = 1'b1;
            if (r_bit_cnt == C_BIT_LAST) w_state_next = STOP;
          end
        end
        STOP: begin
          if (r_tick_cnt == C_TICK_LAST) begin
            w_tick_next  = '0;
            w_state_next = IDLE;
            w_stop_good  = w_rx_s;
            w_stop_bad   = !w_rx_s;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_rx_prev <= 1'b1;
      r_shift   <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rxclk_en) r_rx_prev <= w_rx_s;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (w_stop_good) begin
        data      <= r_shift;
        frame_err <= 1'b0;
        rdy       <= 1'b1;
        // A simultaneous acknowledge means the previous byte was consumed.
        if (rdy_clr)  overrun <= 1'b0;
        else if (rdy) overrun <= 1'b1;
      end else begin
        if (w_stop_bad) frame_err <= 1'b1;
        if (rdy_clr) begin
          rdy     <= 1'b0;
          overrun <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : self-checking bench for uart_rx against a frame-level model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxclk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int rdy_rises = 0, ferr_rises = 0;
  logic rdy_q = 1'b0, ferr_q = 1'b0;

  int          stop_cyc;
  logic        rdy_before, rdy_after;
  logic [10:0] post_rst_snap;

  logic [7:0] exp_data;
  logic       exp_rdy, exp_ferr, exp_ovr;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_50m   (clk),
    .rst       (rst),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The posedge that makes cyc == m sees a tick whenever m % 4 == 0.
  always @(negedge clk) rxclk_en = (((cyc + 1) % 4) == 0);

  always @(posedge clk) begin
    #1;
    if (rdy === 1'b1 && rdy_q !== 1'b1) rdy_rises <= rdy_rises + 1;
    if (frame_err === 1'b1 && ferr_q !== 1'b1) ferr_rises <= ferr_rises + 1;
    rdy_q  <= rdy;
    ferr_q <= frame_err;
  end

  // ---------------- reference model (frame-level sticky-flag rules) --------
  task automatic model_reset();
    exp_data = 8'h00; exp_rdy = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic ok, input logic clr);
    if (ok) begin
      if (clr)          exp_ovr = 1'b0;
      else if (exp_rdy) exp_ovr = 1'b1;
      exp_rdy  = 1'b1;
      exp_data = b;
      exp_ferr = 1'b0;
    end else begin
      exp_ferr = 1'b1;
      if (clr) begin exp_rdy = 1'b0; exp_ovr = 1'b0; end
    end
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) rdy_clr = 1'b1;
    @(negedge clk) rdy_clr = 1'b0;
    exp_rdy = 1'b0; exp_ovr = 1'b0;
  endtask

  // One 8N1 frame, 64 clocks per bit. The stop sample lands 8 ticks after
  // the first tick that sees the synchronised start bit, plus 9 bit periods.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input logic clr_at_stop, input int rst_at);
    int c, m, idx;
    @(negedge clk);
    c = cyc;
    m = c + 3;
    while (m % 4 != 0) m++;
    stop_cyc = m + 8 * 4 + 9 * 16 * 4;
    for (int i = 0; i < 640; i++) begin
      if (i > 0) @(negedge clk);
      if (cyc == stop_cyc - 1) rdy_before = rdy;
      if (cyc == stop_cyc) rdy_after = rdy;
      if (i == rst_at + 1) post_rst_snap = {data, rdy, frame_err, overrun};
      idx = i / 64;
      rx = (idx == 0) ? 1'b0 : (idx <= 8) ? b[idx-1] : stop_val;
      rdy_clr = clr_at_stop && (cyc == stop_cyc - 1);
      rst = (i == rst_at);
    end
    @(negedge clk);
    rx = 1'b1; rdy_clr = 1'b0; rst = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    model_reset();
    idle(2);
    n_total++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else n_pass++;
    n_total++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", rdy); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", overrun); else n_pass++;
    idle(20);
  endtask

  task automatic test_good_byte();
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    model_frame(8'hA5, 1'b1, 1'b0);
    n_total++; if ({rdy_before, rdy_after} !== 2'b01)
      $display("FAIL good_latency: got before/after %b%b expected 01", rdy_before, rdy_after); else n_pass++;
    n_total++; if ({data, rdy, frame_err, overrun} !== {8'hA5, 3'b100})
      $display("FAIL good_byte: got %h %b%b%b expected a5 100", data, rdy, frame_err, overrun); else n_pass++;
    pulse_clr();
    n_total++; if ({data, rdy} !== {8'hA5, 1'b0})
      $display("FAIL good_clr: got %h rdy=%b expected a5 rdy=0", data, rdy); else n_pass++;
    idle(16);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rdy_rises;
    send_frame(8'h00, 1'b1, 1'b0, -1);
    model_frame(8'h00, 1'b1, 1'b0);
    n_total++; if ({data, rdy, overrun} !== {8'h00, 2'b10} || rdy_rises != r0 + 1)
      $display("FAIL b2b_first: got %h rdy=%b ovr=%b rises=%0d expected 00 1 0 %0d",
               data, rdy, overrun, rdy_rises - r0, 1); else n_pass++;
    pulse_clr();
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    model_frame(8'hFF, 1'b1, 1'b0);
    n_total++; if ({data, rdy, overrun} !== {8'hFF, 2'b10} || rdy_rises != r0 + 2)
      $display("FAIL b2b_second: got %h rdy=%b ovr=%b rises=%0d expected ff 1 0 %0d",
               data, rdy, overrun, rdy_rises - r0, 2); else n_pass++;
    pulse_clr();
    idle(16);
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle(12);
    n_total++; if ({data, rdy, frame_err} !== {8'hFF, 2'b01})
      $display("FAIL ferr_set: got %h rdy=%b ferr=%b expected ff 0 1", data, rdy, frame_err); else n_pass++;
    send_frame(8'h55, 1'b1, 1'b0, -1);
    model_frame(8'h55, 1'b1, 1'b0);
    n_total++; if ({data, rdy, frame_err} !== {8'h55, 2'b10})
      $display("FAIL ferr_recover: got %h rdy=%b ferr=%b expected 55 1 0", data, rdy, frame_err); else n_pass++;
    pulse_clr();
    idle(16);
  endtask

  task automatic test_glitch();
    int r0;
    r0 = rdy_rises;
    for (int i = 0; i < 16; i++) begin @(negedge clk); rx = 1'b0; end
    @(negedge clk); rx = 1'b1;
    idle(700);
    n_total++; if ({rdy, frame_err} !== 2'b00 || rdy_rises != r0)
      $display("FAIL glitch: got rdy=%b ferr=%b rises=%0d expected 0 0 0", rdy, frame_err, rdy_rises - r0); else n_pass++;
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    model_frame(8'hC3, 1'b1, 1'b0);
    n_total++; if ({data, rdy} !== {8'hC3, 1'b1})
      $display("FAIL glitch_next: got %h rdy=%b expected c3 1", data, rdy); else n_pass++;
    pulse_clr();
    idle(16);
  endtask

  task automatic test_break();
    int r0, f0;
    r0 = rdy_rises; f0 = ferr_rises;
    for (int i = 0; i < 20 * 64; i++) begin @(negedge clk); rx = 1'b0; end
    model_frame(8'h00, 1'b0, 1'b0);
    n_total++; if ({data, rdy, frame_err} !== {exp_data, 2'b01} || ferr_rises != f0 + 1 || rdy_rises != r0)
      $display("FAIL break: got %h rdy=%b ferr=%b ferr_events=%0d rdy_events=%0d expected %h 0 1 1 0",
               data, rdy, frame_err, ferr_rises - f0, rdy_rises - r0, exp_data); else n_pass++;
    @(negedge clk); rx = 1'b1;
    idle(64);
    send_frame(8'h96, 1'b1, 1'b0, -1);
    model_frame(8'h96, 1'b1, 1'b0);
    n_total++; if ({data, rdy, frame_err} !== {8'h96, 2'b10})
      $display("FAIL break_next: got %h rdy=%b ferr=%b expected 96 1 0", data, rdy, frame_err); else n_pass++;
    idle(16);
  endtask

  task automatic test_overrun();
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b0, -1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(16);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    model_frame(8'h22, 1'b1, 1'b0);
    n_total++; if ({data, rdy, overrun} !== {8'h22, 2'b11})
      $display("FAIL overrun: got %h rdy=%b ovr=%b expected 22 1 1", data, rdy, overrun); else n_pass++;
    pulse_clr();
    n_total++; if ({rdy, overrun} !== 2'b00)
      $display("FAIL overrun_clr: got rdy=%b ovr=%b expected 0 0", rdy, overrun); else n_pass++;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(16);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    model_frame(8'h22, 1'b1, 1'b1);
    n_total++; if ({data, rdy, overrun, rdy_after} !== {8'h22, 3'b101})
      $display("FAIL coincide: got %h rdy=%b ovr=%b rdy_at_stop=%b expected 22 1 0 1",
               data, rdy, overrun, rdy_after); else n_pass++;
    idle(16);
  endtask

  task automatic test_reset_midframe();
    // Reset lands mid bit 3; the still-low line then looks like a fresh start.
    send_frame(8'h81, 1'b1, 1'b0, 4 * 64 + 32);
    model_reset();
    n_total++; if (post_rst_snap !== 11'h000)
      $display("FAIL midrst_outputs: got %h expected 000", post_rst_snap); else n_pass++;
    idle(700);
    pulse_clr();
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    model_frame(8'h7E, 1'b1, 1'b0);
    n_total++; if ({data, rdy, frame_err, overrun} !== {8'h7E, 3'b100})
      $display("FAIL midrst_next: got %h %b%b%b expected 7e 100", data, rdy, frame_err, overrun); else n_pass++;
    idle(16);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       ok;
    int         mode;
    for (int k = 0; k < 10; k++) begin
      b    = 8'($urandom);
      ok   = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 2);
      if (mode == 1) pulse_clr();
      send_frame(b, ok, (mode == 2), -1);
      model_frame(b, ok, (mode == 2));
      n_total++; if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_ferr, exp_ovr})
        $display("FAIL random_%0d: got %h %b%b%b expected %h %b%b%b (sent %h ok=%b mode=%0d)",
                 k, data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_ferr, exp_ovr, b, ok, mode);
      else n_pass++;
      idle(8 + $urandom_range(0, 31));
    end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
